udma_sdio_reg_if_mc: RTL and testbench

Parametrised configuration and status register file for the next-generation uDMA SDIO peripheral. It sits between the uDMA config bus and the SDIO controller core. It provides N_CH uDMA channel register banks, command, argument and data-setup registers, and a clock-divider handshake with a one-deep pending buffer. New over the current interface: sticky event/error status with write-1-to-clear, interrupt masking, start rejection while busy, and response capture at end of transfer.

---
 rtl/udma_sdio_pkg.sv | 37 +++
 rtl/udma_sdio_clkdiv_hs.sv | 83 ++++++++
 rtl/udma_sdio_reg_if_mc.sv | 251 +++++++++++++++++++++++++
 tb/tb_udma_sdio_reg_if_mc.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_sdio_pkg.sv
// Shared constants for the uDMA SDIO register interface: register offsets
// relative to the end of the channel banks, STATUS bit positions and the
// clock-divider handshake state encoding.
package udma_sdio_pkg;

    // Offsets from B = 4*N_CH (word addresses)
    localparam int OFF_CMD_OP     = 0;
    localparam int OFF_CMD_ARG    = 1;
    localparam int OFF_DATA_SETUP = 2;
    localparam int OFF_START      = 3;
    localparam int OFF_STATUS     = 4;
    localparam int OFF_CLK_DIV    = 5;
    localparam int OFF_IRQ_EN     = 6;
    localparam int OFF_RSP0       = 8;

    // Channel bank layout (per channel, 4 words)
    localparam int CH_SADDR = 0;
    localparam int CH_SIZE  = 1;
    localparam int CH_CFG   = 2;

    // STATUS bit indices
    localparam int STAT_EOT     = 0;
    localparam int STAT_ERR     = 1;
    localparam int STAT_REJ     = 2;
    localparam int STAT_CD_BUSY = 3;

    // CLK_DIV write is only a request when this bit is set
    localparam int CLKDIV_REQ_BIT = 8;

    typedef enum logic [1:0] {
        CD_IDLE     = 2'd0,
        CD_REQ      = 2'd1,
        CD_REQ_PEND = 2'd2,
        CD_IDLE_GAP = 2'd3
    } clkdiv_state_e;

endpackage

// File: rtl/udma_sdio_clkdiv_hs.sv
// Clock-divider request/ack handshake with a one-deep pending buffer.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// CD_IDLE     | no request outstanding, valid low
// CD_REQ      | request presented, waiting for ack
// CD_REQ_PEND | request presented, a newer value is waiting in the shadow
// CD_IDLE_GAP | one cycle with valid low before presenting the shadow value
module udma_sdio_clkdiv_hs
    import udma_sdio_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       wr_i,
    input  logic [7:0] wdata_i,
    input  logic       ack_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       busy_o
);

    clkdiv_state_e state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    shadow_q, shadow_d;

    // State, presented value and shadow registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= CD_IDLE;
            data_q   <= 8'h00;
            shadow_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
        end
    end

    // Next-state logic; an ack arriving together with a new write still
    // retires the current request and the new value follows after the gap
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        shadow_d = shadow_q;
        case (state_q)
            CD_IDLE: begin
                if (wr_i) begin
                    data_d  = wdata_i;
                    state_d = CD_REQ;
                end
            end
            CD_REQ: begin
                if (wr_i) begin
                    shadow_d = wdata_i;
                    state_d  = ack_i ? CD_IDLE_GAP : CD_REQ_PEND;
                end else if (ack_i) begin
                    state_d = CD_IDLE;
                end
            end
            CD_REQ_PEND: begin
                if (wr_i) begin
                    shadow_d = wdata_i;
                end
                if (ack_i) begin
                    state_d = CD_IDLE_GAP;
                end
            end
            CD_IDLE_GAP: begin
                data_d   = wr_i ? wdata_i : shadow_q;
                shadow_d = data_d;
                state_d  = CD_REQ;
            end
            default: begin
                state_d = CD_IDLE;
            end
        endcase
    end

    assign data_o  = data_q;
    assign valid_o = (state_q == CD_REQ) || (state_q == CD_REQ_PEND);
    assign busy_o  = (state_q != CD_IDLE);

endmodule

// File: rtl/udma_sdio_reg_if_mc.sv
// Configuration/status register file between the uDMA config bus and the
// SDIO controller core: channel banks, command/data setup, sticky status
// with write-1-to-clear, interrupt masking and response capture.
module udma_sdio_reg_if_mc
    import udma_sdio_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int N_CH           = 2,
    parameter int ADDR_WIDTH     = 6
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [31:0]                    cfg_data_i,
    input  logic [ADDR_WIDTH-1:0]          cfg_addr_i,
    input  logic                           cfg_valid_i,
    input  logic                           cfg_rwn_i,
    output logic [31:0]                    cfg_data_o,
    output logic                           cfg_ready_o,
    output logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_ch_startaddr_o,
    output logic [N_CH*TRANS_SIZE-1:0]     cfg_ch_size_o,
    output logic [N_CH-1:0]                cfg_ch_continuous_o,
    output logic [N_CH-1:0]                cfg_ch_en_o,
    output logic [N_CH-1:0]                cfg_ch_clr_o,
    input  logic [N_CH-1:0]                cfg_ch_en_i,
    input  logic [N_CH-1:0]                cfg_ch_pending_i,
    input  logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_ch_curr_addr_i,
    input  logic [N_CH*TRANS_SIZE-1:0]     cfg_ch_bytes_left_i,
    output logic [5:0]                     cfg_cmd_op_o,
    output logic [2:0]                     cfg_cmd_rsp_type_o,
    output logic [31:0]                    cfg_cmd_arg_o,
    output logic                           cfg_data_en_o,
    output logic                           cfg_data_rwn_o,
    output logic                           cfg_data_quad_o,
    output logic [9:0]                     cfg_data_block_size_o,
    output logic [7:0]                     cfg_data_block_num_o,
    output logic                           cfg_sdio_start_o,
    input  logic                           sdio_busy_i,
    input  logic                           sdio_eot_i,
    input  logic                           sdio_err_i,
    input  logic [7:0]                     sdio_err_code_i,
    input  logic [127:0]                   cfg_rsp_data_i,
    output logic [7:0]                     cfg_clk_div_data_o,
    output logic                           cfg_clk_div_valid_o,
    input  logic                           cfg_clk_div_ack_i,
    output logic                           irq_o
);

    localparam int AW = L2_AWIDTH_NOAL;
    localparam int TS = TRANS_SIZE;
    localparam int B  = 4 * N_CH;

    localparam logic [31:0] A_CMD_OP     = 32'(B + OFF_CMD_OP);
    localparam logic [31:0] A_CMD_ARG    = 32'(B + OFF_CMD_ARG);
    localparam logic [31:0] A_DATA_SETUP = 32'(B + OFF_DATA_SETUP);
    localparam logic [31:0] A_START      = 32'(B + OFF_START);
    localparam logic [31:0] A_STATUS     = 32'(B + OFF_STATUS);
    localparam logic [31:0] A_CLK_DIV    = 32'(B + OFF_CLK_DIV);
    localparam logic [31:0] A_IRQ_EN     = 32'(B + OFF_IRQ_EN);
    localparam logic [31:0] A_RSP0       = 32'(B + OFF_RSP0);

    logic [31:0]        addr_w;
    logic               wr_en;

    logic [N_CH*AW-1:0] saddr_q;
    logic [N_CH*TS-1:0] size_q;
    logic [N_CH-1:0]    cont_q;
    logic [N_CH-1:0]    en_q;
    logic [N_CH-1:0]    clr_q;

    logic [5:0]         cmd_op_q;
    logic [2:0]         rsp_type_q;
    logic [31:0]        arg_q;
    logic               data_en_q;
    logic               data_rwn_q;
    logic               data_quad_q;
    logic [9:0]         bsize_q;
    logic [7:0]         bnum_q;
    logic               start_q;

    logic [2:0]         status_q, status_d;
    logic [2:0]         status_set, status_clr;
    logic [7:0]         err_code_q;
    logic [2:0]         irq_en_q;
    logic               irq_q;
    logic [127:0]       rsp_q;

    logic               start_req;
    logic               start_rej;
    logic               clkdiv_wr;
    logic               clkdiv_busy;

    assign addr_w    = 32'(cfg_addr_i);
    assign wr_en     = cfg_valid_i & ~cfg_rwn_i;
    assign start_req = wr_en && (addr_w == A_START) && cfg_data_i[0];
    assign start_rej = start_req & sdio_busy_i;
    assign clkdiv_wr = wr_en && (addr_w == A_CLK_DIV) && cfg_data_i[CLKDIV_REQ_BIT];

    // Sticky status: clear the written-1 bits first so a coincident event wins
    assign status_clr = (wr_en && (addr_w == A_STATUS)) ? cfg_data_i[2:0] : 3'b000;
    assign status_set = {start_rej, sdio_err_i, sdio_eot_i};
    assign status_d   = (status_q & ~status_clr) | status_set;

    // Channel bank registers and one-cycle enable/clear pulses
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            saddr_q <= '0;
            size_q  <= '0;
            cont_q  <= '0;
            en_q    <= '0;
            clr_q   <= '0;
        end else begin
            en_q  <= '0;
            clr_q <= '0;
            if (wr_en) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (addr_w == 32'(4*c + CH_SADDR)) begin
                        saddr_q[c*AW +: AW] <= cfg_data_i[AW-1:0];
                    end
                    if (addr_w == 32'(4*c + CH_SIZE)) begin
                        size_q[c*TS +: TS] <= cfg_data_i[TS-1:0];
                    end
                    if (addr_w == 32'(4*c + CH_CFG)) begin
                        cont_q[c] <= cfg_data_i[0];
                        en_q[c]   <= cfg_data_i[4];
                        clr_q[c]  <= cfg_data_i[5];
                    end
                end
            end
        end
    end

    // Command, argument, data-setup registers and the start pulse
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cmd_op_q    <= '0;
            rsp_type_q  <= '0;
            arg_q       <= '0;
            data_en_q   <= 1'b0;
            data_rwn_q  <= 1'b0;
            data_quad_q <= 1'b0;
            bsize_q     <= '0;
            bnum_q      <= '0;
            start_q     <= 1'b0;
        end else begin
            start_q <= start_req & ~sdio_busy_i;
            if (wr_en && (addr_w == A_CMD_OP)) begin
                cmd_op_q   <= cfg_data_i[5:0];
                rsp_type_q <= cfg_data_i[10:8];
            end
            if (wr_en && (addr_w == A_CMD_ARG)) begin
                arg_q <= cfg_data_i;
            end
            if (wr_en && (addr_w == A_DATA_SETUP)) begin
                data_en_q   <= cfg_data_i[0];
                data_rwn_q  <= cfg_data_i[1];
                data_quad_q <= cfg_data_i[2];
                bnum_q      <= cfg_data_i[15:8];
                bsize_q     <= cfg_data_i[25:16];
            end
        end
    end

    // Status, error code, interrupt enable/output and response capture
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            status_q   <= '0;
            err_code_q <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
            rsp_q      <= '0;
        end else begin
            status_q <= status_d;
            irq_q    <= |(status_q & irq_en_q);
            if (sdio_err_i) begin
                err_code_q <= sdio_err_code_i;
            end
            if (wr_en && (addr_w == A_IRQ_EN)) begin
                irq_en_q <= cfg_data_i[2:0];
            end
            if (sdio_eot_i) begin
                rsp_q <= cfg_rsp_data_i;
            end
        end
    end

    // Combinational read mux; SADDR/SIZE return live DMA progress
    always_comb begin
        cfg_data_o = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (addr_w == 32'(4*c + CH_SADDR)) begin
                cfg_data_o[AW-1:0] = cfg_ch_curr_addr_i[c*AW +: AW];
            end
            if (addr_w == 32'(4*c + CH_SIZE)) begin
                cfg_data_o[TS-1:0] = cfg_ch_bytes_left_i[c*TS +: TS];
            end
            if (addr_w == 32'(4*c + CH_CFG)) begin
                cfg_data_o[5:0] = {cfg_ch_pending_i[c], cfg_ch_en_i[c], 3'b000, cont_q[c]};
            end
        end
        if (addr_w == A_CMD_OP) begin
            cfg_data_o[10:0] = {rsp_type_q, 2'b00, cmd_op_q};
        end
        if (addr_w == A_CMD_ARG) begin
            cfg_data_o = arg_q;
        end
        if (addr_w == A_DATA_SETUP) begin
            cfg_data_o[25:0] = {bsize_q, bnum_q, 5'b00000, data_quad_q, data_rwn_q, data_en_q};
        end
        if (addr_w == A_STATUS) begin
            cfg_data_o[15:0] = {err_code_q, 4'b0000, clkdiv_busy, status_q};
        end
        if (addr_w == A_IRQ_EN) begin
            cfg_data_o[2:0] = irq_en_q;
        end
        for (int k = 0; k < 4; k++) begin
            if (addr_w == A_RSP0 + 32'(k)) begin
                cfg_data_o = rsp_q[32*k +: 32];
            end
        end
    end

    udma_sdio_clkdiv_hs u_clkdiv_hs (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .wr_i    (clkdiv_wr),
        .wdata_i (cfg_data_i[7:0]),
        .ack_i   (cfg_clk_div_ack_i),
        .data_o  (cfg_clk_div_data_o),
        .valid_o (cfg_clk_div_valid_o),
        .busy_o  (clkdiv_busy)
    );

    assign cfg_ready_o           = 1'b1;
    assign cfg_ch_startaddr_o    = saddr_q;
    assign cfg_ch_size_o         = size_q;
    assign cfg_ch_continuous_o   = cont_q;
    assign cfg_ch_en_o           = en_q;
    assign cfg_ch_clr_o          = clr_q;
    assign cfg_cmd_op_o          = cmd_op_q;
    assign cfg_cmd_rsp_type_o    = rsp_type_q;
    assign cfg_cmd_arg_o         = arg_q;
    assign cfg_data_en_o         = data_en_q;
    assign cfg_data_rwn_o        = data_rwn_q;
    assign cfg_data_quad_o       = data_quad_q;
    assign cfg_data_block_size_o = bsize_q;
    assign cfg_data_block_num_o  = bnum_q;
    assign cfg_sdio_start_o      = start_q;
    assign irq_o                 = irq_q;

endmodule

// File: tb/tb_udma_sdio_reg_if_mc.sv
// Self-checking bench for udma_sdio_reg_if_mc (N_CH=2, ADDR_WIDTH=6).
// A behavioural register-map model runs alongside the DUT and every output is
// compared each cycle; directed steps add literal expectations on top.
module tb_udma_sdio_reg_if_mc;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic [31:0]   cfg_data_i;
    logic [5:0]    cfg_addr_i;
    logic          cfg_valid_i;
    logic          cfg_rwn_i;
    logic [31:0]   cfg_data_o;
    logic          cfg_ready_o;
    logic [23:0]   cfg_ch_startaddr_o;
    logic [31:0]   cfg_ch_size_o;
    logic [1:0]    cfg_ch_continuous_o;
    logic [1:0]    cfg_ch_en_o;
    logic [1:0]    cfg_ch_clr_o;
    logic [1:0]    cfg_ch_en_i;
    logic [1:0]    cfg_ch_pending_i;
    logic [23:0]   cfg_ch_curr_addr_i;
    logic [31:0]   cfg_ch_bytes_left_i;
    logic [5:0]    cfg_cmd_op_o;
    logic [2:0]    cfg_cmd_rsp_type_o;
    logic [31:0]   cfg_cmd_arg_o;
    logic          cfg_data_en_o;
    logic          cfg_data_rwn_o;
    logic          cfg_data_quad_o;
    logic [9:0]    cfg_data_block_size_o;
    logic [7:0]    cfg_data_block_num_o;
    logic          cfg_sdio_start_o;
    logic          sdio_busy_i;
    logic          sdio_eot_i;
    logic          sdio_err_i;
    logic [7:0]    sdio_err_code_i;
    logic [127:0]  cfg_rsp_data_i;
    logic [7:0]    cfg_clk_div_data_o;
    logic          cfg_clk_div_valid_o;
    logic          cfg_clk_div_ack_i;
    logic          irq_o;

    always #5 clk_i = ~clk_i;

    udma_sdio_reg_if_mc #(
        .L2_AWIDTH_NOAL (12),
        .TRANS_SIZE     (16),
        .N_CH           (2),
        .ADDR_WIDTH     (6)
    ) dut (
        .clk_i                 (clk_i),
        .rstn_i                (rstn_i),
        .cfg_data_i            (cfg_data_i),
        .cfg_addr_i            (cfg_addr_i),
        .cfg_valid_i           (cfg_valid_i),
        .cfg_rwn_i             (cfg_rwn_i),
        .cfg_data_o            (cfg_data_o),
        .cfg_ready_o           (cfg_ready_o),
        .cfg_ch_startaddr_o    (cfg_ch_startaddr_o),
        .cfg_ch_size_o         (cfg_ch_size_o),
        .cfg_ch_continuous_o   (cfg_ch_continuous_o),
        .cfg_ch_en_o           (cfg_ch_en_o),
        .cfg_ch_clr_o          (cfg_ch_clr_o),
        .cfg_ch_en_i           (cfg_ch_en_i),
        .cfg_ch_pending_i      (cfg_ch_pending_i),
        .cfg_ch_curr_addr_i    (cfg_ch_curr_addr_i),
        .cfg_ch_bytes_left_i   (cfg_ch_bytes_left_i),
        .cfg_cmd_op_o          (cfg_cmd_op_o),
        .cfg_cmd_rsp_type_o    (cfg_cmd_rsp_type_o),
        .cfg_cmd_arg_o         (cfg_cmd_arg_o),
        .cfg_data_en_o         (cfg_data_en_o),
        .cfg_data_rwn_o        (cfg_data_rwn_o),
        .cfg_data_quad_o       (cfg_data_quad_o),
        .cfg_data_block_size_o (cfg_data_block_size_o),
        .cfg_data_block_num_o  (cfg_data_block_num_o),
        .cfg_sdio_start_o      (cfg_sdio_start_o),
        .sdio_busy_i           (sdio_busy_i),
        .sdio_eot_i            (sdio_eot_i),
        .sdio_err_i            (sdio_err_i),
        .sdio_err_code_i       (sdio_err_code_i),
        .cfg_rsp_data_i        (cfg_rsp_data_i),
        .cfg_clk_div_data_o    (cfg_clk_div_data_o),
        .cfg_clk_div_valid_o   (cfg_clk_div_valid_o),
        .cfg_clk_div_ack_i     (cfg_clk_div_ack_i),
        .irq_o                 (irq_o)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- behavioural model ----------------
    logic [11:0] m_saddr [2];
    logic [15:0] m_size  [2];
    logic [1:0]  m_cont, m_en, m_clr;
    logic [5:0]  m_op;
    logic [2:0]  m_rsp_type;
    logic [31:0] m_arg;
    logic        m_den, m_drwn, m_dquad;
    logic [9:0]  m_bsize;
    logic [7:0]  m_bnum;
    logic        m_start;
    logic [2:0]  m_st;
    logic [7:0]  m_code;
    logic [2:0]  m_irqen;
    logic        m_irq;
    logic [31:0] m_rsp [4];
    // divider request: presented value, newer value waiting, gap cycle
    logic        cd_valid, cd_pend, cd_gap;
    logic [7:0]  cd_data, cd_shadow;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_saddr[c] = '0;
            m_size[c]  = '0;
        end
        m_cont = '0; m_en = '0; m_clr = '0;
        m_op = '0; m_rsp_type = '0; m_arg = '0;
        m_den = 1'b0; m_drwn = 1'b0; m_dquad = 1'b0;
        m_bsize = '0; m_bnum = '0; m_start = 1'b0;
        m_st = '0; m_code = '0; m_irqen = '0; m_irq = 1'b0;
        for (int k = 0; k < 4; k++) m_rsp[k] = '0;
        cd_valid = 1'b0; cd_pend = 1'b0; cd_gap = 1'b0;
        cd_data = '0; cd_shadow = '0;
    endtask

    function automatic logic [31:0] m_read(int a);
        logic [31:0] r;
        int c;
        r = '0;
        if (a < 8) begin
            c = a / 4;
            case (a % 4)
                0: r = 32'(cfg_ch_curr_addr_i[c*12 +: 12]);
                1: r = 32'(cfg_ch_bytes_left_i[c*16 +: 16]);
                2: r = 32'({cfg_ch_pending_i[c], cfg_ch_en_i[c], 3'b000, m_cont[c]});
                default: r = '0;
            endcase
        end else begin
            case (a)
                8:  r = 32'(m_op) + (32'(m_rsp_type) << 8);
                9:  r = m_arg;
                10: r = 32'(m_den) + (32'(m_drwn) << 1) + (32'(m_dquad) << 2)
                        + (32'(m_bnum) << 8) + (32'(m_bsize) << 16);
                12: r = 32'(m_st) + (32'(cd_valid | cd_gap) << 3) + (32'(m_code) << 8);
                14: r = 32'(m_irqen);
                16, 17, 18, 19: r = m_rsp[a - 16];
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // advance the model by one clock edge using the inputs currently applied
    task automatic model_step();
        logic        wr, rej, cdwr, irq_n;
        int          a, c;
        logic [31:0] d;
        wr    = cfg_valid_i && !cfg_rwn_i;
        a     = int'({26'b0, cfg_addr_i});
        d     = cfg_data_i;
        irq_n = |(m_st & m_irqen);
        rej   = 1'b0;
        m_en = '0; m_clr = '0; m_start = 1'b0;
        if (wr) begin
            if (a < 8) begin
                c = a / 4;
                case (a % 4)
                    0: m_saddr[c] = d[11:0];
                    1: m_size[c]  = d[15:0];
                    2: begin m_cont[c] = d[0]; m_en[c] = d[4]; m_clr[c] = d[5]; end
                    default: ;
                endcase
            end else begin
                case (a)
                    8:  begin m_op = d[5:0]; m_rsp_type = d[10:8]; end
                    9:  m_arg = d;
                    10: begin
                        m_den = d[0]; m_drwn = d[1]; m_dquad = d[2];
                        m_bnum = d[15:8]; m_bsize = d[25:16];
                    end
                    11: begin
                        if (d[0]) begin
                            if (sdio_busy_i) rej = 1'b1;
                            else m_start = 1'b1;
                        end
                    end
                    12: m_st = m_st & ~d[2:0];
                    14: m_irqen = d[2:0];
                    default: ;
                endcase
            end
        end
        m_st = m_st | {rej, sdio_err_i, sdio_eot_i};
        if (sdio_err_i) m_code = sdio_err_code_i;
        if (sdio_eot_i) for (int k = 0; k < 4; k++) m_rsp[k] = cfg_rsp_data_i[32*k +: 32];
        m_irq = irq_n;
        cdwr = wr && (a == 13) && d[8];
        if (cd_gap) begin
            if (cdwr) cd_shadow = d[7:0];
            cd_data  = cd_shadow;
            cd_valid = 1'b1;
            cd_gap   = 1'b0;
        end else if (!cd_valid) begin
            if (cdwr) begin
                cd_data  = d[7:0];
                cd_valid = 1'b1;
            end
        end else begin
            if (cdwr) begin
                cd_shadow = d[7:0];
                cd_pend   = 1'b1;
            end
            if (cfg_clk_div_ack_i) begin
                cd_valid = 1'b0;
                cd_gap   = cd_pend;
                cd_pend  = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("rdata",     cfg_data_o, m_read(int'({26'b0, cfg_addr_i})));
        chk("ready",     32'(cfg_ready_o), 32'd1);
        chk("saddr",     32'(cfg_ch_startaddr_o), 32'({m_saddr[1], m_saddr[0]}));
        chk("size",      cfg_ch_size_o, {m_size[1], m_size[0]});
        chk("cont",      32'(cfg_ch_continuous_o), 32'(m_cont));
        chk("ch_en",     32'(cfg_ch_en_o), 32'(m_en));
        chk("ch_clr",    32'(cfg_ch_clr_o), 32'(m_clr));
        chk("cmd_op",    32'(cfg_cmd_op_o), 32'(m_op));
        chk("rsp_type",  32'(cfg_cmd_rsp_type_o), 32'(m_rsp_type));
        chk("arg",       cfg_cmd_arg_o, m_arg);
        chk("dsetup",    32'({cfg_data_block_size_o, cfg_data_block_num_o, cfg_data_quad_o,
                              cfg_data_rwn_o, cfg_data_en_o}),
                         32'({m_bsize, m_bnum, m_dquad, m_drwn, m_den}));
        chk("start",     32'(cfg_sdio_start_o), 32'(m_start));
        chk("irq",       32'(irq_o), 32'(m_irq));
        chk("cd_valid",  32'(cfg_clk_div_valid_o), 32'(cd_valid));
        chk("cd_data",   32'(cfg_clk_div_data_o), 32'(cd_data));
    endtask

    // one clock: compare after the inputs settle, then step the model at the edge
    task automatic tick();
        #1;
        if (!rstn_i) model_reset();
        compare_all();
        @(posedge clk_i);
        if (rstn_i) model_step();
        else model_reset();
        @(negedge clk_i);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = a; cfg_data_i = d;
        tick();
        cfg_valid_i = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        cfg_valid_i = 1'b1; cfg_rwn_i = 1'b1; cfg_addr_i = a; cfg_data_i = '0;
        #1;
        d = cfg_data_o;
        tick();
        cfg_valid_i = 1'b0;
    endtask

    logic [31:0] rv;

    initial begin
        rstn_i = 1'b0;
        cfg_data_i = '0; cfg_addr_i = '0; cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1;
        cfg_ch_en_i = '0; cfg_ch_pending_i = '0; cfg_ch_curr_addr_i = '0; cfg_ch_bytes_left_i = '0;
        sdio_busy_i = 1'b0; sdio_eot_i = 1'b0; sdio_err_i = 1'b0; sdio_err_code_i = '0;
        cfg_rsp_data_i = '0; cfg_clk_div_ack_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        tick();
        tick();
        rstn_i = 1'b1;

        // reset state: every mapped register reads zero
        for (int a = 0; a < 20; a++) begin
            rd(6'(a), rv);
            chk("reset_read", rv, 32'h0);
        end
        chk("reset_irq", 32'(irq_o), 32'h0);
        chk("reset_cd_valid", 32'(cfg_clk_div_valid_o), 32'h0);

        // channel 1 CFG: clear + enable pulse, continuous mode
        cfg_ch_en_i = 2'b10; cfg_ch_pending_i = 2'b10;
        wr(6'd6, 32'h31);
        chk("ch_en_pulse", 32'(cfg_ch_en_o), 32'h2);
        chk("ch_clr_pulse", 32'(cfg_ch_clr_o), 32'h2);
        tick();
        chk("ch_en_after", 32'(cfg_ch_en_o), 32'h0);
        chk("ch_clr_after", 32'(cfg_ch_clr_o), 32'h0);
        chk("ch_cont", 32'(cfg_ch_continuous_o), 32'h2);
        rd(6'd6, rv);
        chk("ch1_cfg_read", rv, 32'h31);

        // start while busy is rejected and raises the sticky flag
        sdio_busy_i = 1'b1;
        wr(6'd11, 32'h1);
        chk("start_rejected_pulse", 32'(cfg_sdio_start_o), 32'h0);
        rd(6'd12, rv);
        chk("status_rej", rv, 32'h4);
        sdio_busy_i = 1'b0;
        wr(6'd14, 32'h4);
        tick();
        chk("irq_set", 32'(irq_o), 32'h1);
        wr(6'd12, 32'h4);
        tick();
        chk("irq_cleared", 32'(irq_o), 32'h0);

        // error event beats a coincident write-1-to-clear
        sdio_err_i = 1'b1; sdio_err_code_i = 8'h5A;
        wr(6'd12, 32'h2);
        sdio_err_i = 1'b0; sdio_err_code_i = 8'h00;
        rd(6'd12, rv);
        chk("status_err_wins", rv, 32'h5A02);

        // divider: second request queued behind the first
        wr(6'd13, 32'h103);
        chk("cd_first_valid", 32'(cfg_clk_div_valid_o), 32'h1);
        chk("cd_first_data", 32'(cfg_clk_div_data_o), 32'h03);
        wr(6'd13, 32'h107);
        chk("cd_hold_data", 32'(cfg_clk_div_data_o), 32'h03);
        cfg_clk_div_ack_i = 1'b1;
        tick();
        cfg_clk_div_ack_i = 1'b0;
        chk("cd_gap", 32'(cfg_clk_div_valid_o), 32'h0);
        tick();
        chk("cd_second_valid", 32'(cfg_clk_div_valid_o), 32'h1);
        chk("cd_second_data", 32'(cfg_clk_div_data_o), 32'h07);
        rd(6'd12, rv);
        chk("status_cd_busy", rv, 32'h5A0A);
        cfg_clk_div_ack_i = 1'b1;
        tick();
        cfg_clk_div_ack_i = 1'b0;
        chk("cd_done", 32'(cfg_clk_div_valid_o), 32'h0);
        rd(6'd12, rv);
        chk("status_cd_idle", rv, 32'h5A02);

        // response capture at end of transfer
        cfg_rsp_data_i = {96'h0123_4567_89AB_CDEF_1122_3344, 32'hDEADBEEF};
        sdio_eot_i = 1'b1;
        tick();
        sdio_eot_i = 1'b0;
        cfg_rsp_data_i = {$urandom, $urandom, $urandom, $urandom};
        rd(6'd16, rv);
        chk("rsp0", rv, 32'hDEADBEEF);
        rd(6'd12, rv);
        chk("status_eot", rv, 32'h5A03);

        // randomized traffic against the model, with a reset part way through
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                rstn_i = 1'b0;
                tick();
                rstn_i = 1'b1;
            end
            cfg_valid_i         = ($urandom_range(0, 3) != 0);
            cfg_rwn_i           = $urandom_range(0, 1) == 1;
            cfg_addr_i          = 6'($urandom_range(0, 23));
            cfg_data_i          = $urandom;
            cfg_ch_en_i         = 2'($urandom);
            cfg_ch_pending_i    = 2'($urandom);
            cfg_ch_curr_addr_i  = 24'($urandom);
            cfg_ch_bytes_left_i = $urandom;
            sdio_busy_i         = $urandom_range(0, 1) == 1;
            sdio_eot_i          = ($urandom_range(0, 7) == 0);
            sdio_err_i          = ($urandom_range(0, 7) == 0);
            sdio_err_code_i     = 8'($urandom);
            cfg_rsp_data_i      = {$urandom, $urandom, $urandom, $urandom};
            cfg_clk_div_ack_i   = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
